// File: rtl/test_status_mon_pkg.sv
// Shared definitions for the test status monitor: FSM state encoding and
// default done/pass register values.
package test_status_mon_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StDone    = 2'd2,
        StTimeout = 2'd3
    } state_e;

    localparam int unsigned DefDoneVal = 0;
    localparam int unsigned DefPassVal = 0;

    // Wide enough for STABLE_CYCLES up to 255.
    localparam int unsigned StableCntW = 8;

endpackage

// File: rtl/test_status_ch.sv
// Per-channel arm / stability / done / fail tracking for the test status monitor.
module test_status_ch
    import test_status_mon_pkg::*;
#(
    parameter int unsigned       DATA_W        = 32,
    parameter logic [DATA_W-1:0] DONE_VAL      = DATA_W'(DefDoneVal),
    parameter logic [DATA_W-1:0] PASS_VAL      = DATA_W'(DefPassVal),
    parameter int unsigned       STABLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [DATA_W-1:0] done_reg_i,
    input  logic [DATA_W-1:0] pass_reg_i,
    output logic              armed_o,
    output logic              done_o,
    output logic              fail_o
);

    logic                  armed_q, armed_d;
    logic                  done_q, done_d;
    logic                  fail_q, fail_d;
    logic [StableCntW-1:0] cnt_q, cnt_d;
    logic                  match;

    assign match = (done_reg_i == DONE_VAL);

    always_comb begin
        armed_d = armed_q;
        done_d  = done_q;
        fail_d  = fail_q;
        cnt_d   = cnt_q;
        if (!en_i) begin
            // A disabled channel holds no state, so its mask bits stay low.
            armed_d = 1'b0;
            done_d  = 1'b0;
            fail_d  = 1'b0;
            cnt_d   = '0;
        end else if (!done_q) begin
            if (!match) begin
                armed_d = 1'b1;
            end
            if (armed_q) begin
                if (match) begin
                    cnt_d = cnt_q + StableCntW'(1);
                    if (cnt_d == StableCntW'(STABLE_CYCLES)) begin
                        done_d = 1'b1;
                        fail_d = (pass_reg_i != PASS_VAL);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            armed_q <= armed_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            cnt_q   <= cnt_d;
        end
    end

    assign armed_o = armed_q;
    assign done_o  = done_q;
    assign fail_o  = fail_q;

endmodule

// File: rtl/test_status_mon.sv
// Test status monitor: watches per-hart done/pass registers and reports
// finished / passed / timed-out with a saturating cycle counter.
module test_status_mon
    import test_status_mon_pkg::*;
#(
    parameter int unsigned       NUM_CH         = 1,
    parameter int unsigned       DATA_W         = 32,
    parameter logic [DATA_W-1:0] DONE_VAL       = DATA_W'(DefDoneVal),
    parameter logic [DATA_W-1:0] PASS_VAL       = DATA_W'(DefPassVal),
    parameter int unsigned       STABLE_CYCLES  = 2,
    parameter int unsigned       TIMEOUT_CYCLES = 1000000,
    parameter int unsigned       CNT_W          = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic [NUM_CH-1:0]        ch_en_i,
    input  logic [NUM_CH*DATA_W-1:0] done_reg_i,
    input  logic [NUM_CH*DATA_W-1:0] pass_reg_i,
    output logic                     over_o,
    output logic                     succ_o,
    output logic                     timeout_o,
    output logic [NUM_CH-1:0]        done_mask_o,
    output logic [NUM_CH-1:0]        fail_mask_o,
    output logic [CNT_W-1:0]         cycle_cnt_o
);

    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

    logic              soft_rst;
    logic [NUM_CH-1:0] armed, done, fail;
    logic              all_done, any_armed, timeout_hit;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;

    assign soft_rst = rst | clr_i;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        test_status_ch #(
            .DATA_W        (DATA_W),
            .DONE_VAL      (DONE_VAL),
            .PASS_VAL      (PASS_VAL),
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_ch (
            .clk        (clk),
            .rst        (soft_rst),
            .en_i       (ch_en_i[k]),
            .done_reg_i (done_reg_i[k*DATA_W +: DATA_W]),
            .pass_reg_i (pass_reg_i[k*DATA_W +: DATA_W]),
            .armed_o    (armed[k]),
            .done_o     (done[k]),
            .fail_o     (fail[k])
        );
    end

    assign all_done    = &(done | ~ch_en_i);
    assign any_armed   = |armed;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_cnt_q == TimeoutLast);

    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        // Completion is checked before timeout so it wins a same-cycle tie.
        case (state_q)
            StIdle: begin
                if (all_done) begin
                    state_d = StDone;
                end else if (timeout_hit) begin
                    state_d = StTimeout;
                end else if (any_armed) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (all_done) begin
                    state_d = StDone;
                end else if (timeout_hit) begin
                    state_d = StTimeout;
                end
            end
            StDone, StTimeout: begin
                state_d = state_q;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if ((state_q == StIdle || state_q == StRun) && (cycle_cnt_q != '1)) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (soft_rst) begin
            state_q     <= StIdle;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign over_o      = (state_q == StDone) || (state_q == StTimeout);
    assign succ_o      = (state_q == StDone) && (fail == '0);
    assign timeout_o   = (state_q == StTimeout);
    assign done_mask_o = done;
    assign fail_mask_o = fail;
    assign cycle_cnt_o = cycle_cnt_q;

endmodule

// File: tb/tb_test_status_mon.sv
// Bench for test_status_mon: directed scenarios plus random runs checked
// against a history-based reference model.
module tb_test_status_mon;

    localparam int unsigned NCH    = 2;
    localparam int unsigned DW     = 32;
    localparam int unsigned STABLE = 2;
    localparam int unsigned TO     = 1000;
    localparam int unsigned CW     = 32;
    localparam int unsigned HMAX   = 2048;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr_i;
    logic [NCH-1:0]    ch_en;
    logic [NCH*DW-1:0] done_reg;
    logic [NCH*DW-1:0] pass_reg;
    logic              over_o, succ_o, timeout_o;
    logic [NCH-1:0]    done_mask_o, fail_mask_o;
    logic [CW-1:0]     cycle_cnt_o;

    int tests = 0;
    int fails = 0;

    // Reference model: raw sample history per channel since reset/clear.
    logic [DW-1:0] h_done [NCH][HMAX];
    logic [DW-1:0] h_pass [NCH][HMAX];
    int            h_len  [NCH];
    bit            m_done [NCH];
    bit            m_fail [NCH];
    bit            m_over, m_to;
    logic [CW-1:0] m_cnt;

    test_status_mon #(
        .NUM_CH         (NCH),
        .DATA_W         (DW),
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (clr_i),
        .ch_en_i     (ch_en),
        .done_reg_i  (done_reg),
        .pass_reg_i  (pass_reg),
        .over_o      (over_o),
        .succ_o      (succ_o),
        .timeout_o   (timeout_o),
        .done_mask_o (done_mask_o),
        .fail_mask_o (fail_mask_o),
        .cycle_cnt_o (cycle_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            h_len[k]  = 0;
            m_done[k] = 1'b0;
            m_fail[k] = 1'b0;
        end
        m_over = 1'b0;
        m_to   = 1'b0;
        m_cnt  = '0;
    endtask

    // A channel is done at the first sample j whose last STABLE samples all
    // equal DONE_VAL and all come strictly after the first non-DONE_VAL sample.
    task automatic eval_ch();
        for (int k = 0; k < NCH; k++) begin
            int  a;
            bit  ok;
            a         = -1;
            m_done[k] = 1'b0;
            m_fail[k] = 1'b0;
            for (int i = 0; i < h_len[k]; i++) begin
                if (h_done[k][i] != 0) begin
                    a = i;
                    break;
                end
            end
            if (a >= 0) begin
                for (int j = a + STABLE; j < h_len[k]; j++) begin
                    ok = 1'b1;
                    for (int t = j - STABLE + 1; t <= j; t++) begin
                        if (h_done[k][t] != 0) ok = 1'b0;
                    end
                    if (ok) begin
                        m_done[k] = 1'b1;
                        m_fail[k] = (h_pass[k][j] != 0);
                        break;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        logic [NCH-1:0] dm, fm;
        for (int k = 0; k < NCH; k++) begin
            dm[k] = m_done[k];
            fm[k] = m_fail[k];
        end
        chk("over", over_o, m_over);
        chk("succ", succ_o, m_over && !m_to && (fm == 0));
        chk("timeout", timeout_o, m_to);
        chk("done_mask", done_mask_o, dm);
        chk("fail_mask", fail_mask_o, fm);
        chk("cycle_cnt", cycle_cnt_o, m_cnt);
    endtask

    task automatic tick();
        bit all_dn;
        all_dn = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            if (ch_en[k] && !m_done[k]) all_dn = 1'b0;
        end
        @(posedge clk);
        if (rst || clr_i) begin
            model_reset();
        end else begin
            if (!m_over) begin
                if (all_dn) begin
                    m_over = 1'b1;
                end else if (m_cnt == CW'(TO - 1)) begin
                    m_over = 1'b1;
                    m_to   = 1'b1;
                end
                if (m_cnt != '1) m_cnt = m_cnt + 1;
            end
            for (int k = 0; k < NCH; k++) begin
                if (!ch_en[k]) begin
                    h_len[k] = 0;
                end else if (h_len[k] < HMAX) begin
                    h_done[k][h_len[k]] = done_reg[k*DW +: DW];
                    h_pass[k][h_len[k]] = pass_reg[k*DW +: DW];
                    h_len[k]++;
                end
            end
            eval_ch();
        end
        #1;
        check_all();
    endtask

    task automatic set_regs(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                            input logic [DW-1:0] p0, input logic [DW-1:0] p1);
        done_reg = {d1, d0};
        pass_reg = {p1, p0};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        clr_i = 1'b0;
        ch_en = '1;
        set_regs(0, 0, 0, 0);
        model_reset();
        tick();
        tick();
        chk("rst_over", over_o, 0);
        chk("rst_cnt", cycle_cnt_o, 0);

        // Both armed, then stable from cycle 10: finished after edge 13.
        rst = 1'b0;
        set_regs(1, 1, 0, 0);
        repeat (10) tick();
        set_regs(0, 0, 0, 0);
        tick();
        tick();
        chk("s1_over_e12", over_o, 0);
        tick();
        chk("s1_over_e13", over_o, 1);
        chk("s1_succ", succ_o, 1);
        chk("s1_mask", done_mask_o, 2'b11);
        repeat (3) tick();
        chk("s1_cnt_frozen", cycle_cnt_o, 13);

        // Soft clear from DONE, then a full rerun.
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        chk("clr_over", over_o, 0);
        chk("clr_mask", done_mask_o, 0);
        chk("clr_cnt", cycle_cnt_o, 0);
        set_regs(1, 1, 0, 0);
        repeat (3) tick();
        set_regs(0, 0, 0, 0);
        repeat (3) tick();
        chk("rerun_over", over_o, 1);
        chk("rerun_succ", succ_o, 1);

        // Channel 1 reports failure.
        do_reset();
        set_regs(1, 1, 0, 5);
        repeat (3) tick();
        set_regs(0, 0, 0, 5);
        repeat (3) tick();
        chk("fail_over", over_o, 1);
        chk("fail_succ", succ_o, 0);
        chk("fail_mask", fail_mask_o, 2'b10);
        chk("fail_to", timeout_o, 0);
        set_regs(7, 7, 0, 0);
        tick();
        chk("fail_sticky", fail_mask_o, 2'b10);

        // One-cycle glitch to DONE_VAL must not latch.
        do_reset();
        set_regs(1, 1, 0, 0);
        repeat (3) tick();
        set_regs(0, 0, 0, 0);
        tick();
        set_regs(1, 1, 0, 0);
        repeat (5) tick();
        chk("glitch_mask", done_mask_o, 0);
        chk("glitch_over", over_o, 0);
        set_regs(0, 0, 0, 0);
        repeat (3) tick();
        chk("glitch_then_done", over_o, 1);

        // Never armed: timeout at cycle 1000.
        do_reset();
        set_regs(0, 0, 0, 0);
        repeat (999) tick();
        chk("to_before", timeout_o, 0);
        tick();
        chk("to_flag", timeout_o, 1);
        chk("to_over", over_o, 1);
        chk("to_succ", succ_o, 0);
        chk("to_cnt", cycle_cnt_o, 1000);
        repeat (5) tick();
        chk("to_cnt_frozen", cycle_cnt_o, 1000);

        // Final done and timeout on the same edge: done wins.
        do_reset();
        set_regs(1, 1, 0, 0);
        repeat (997) tick();
        set_regs(0, 0, 0, 0);
        tick();
        tick();
        chk("tie_pre", over_o, 0);
        tick();
        chk("tie_over", over_o, 1);
        chk("tie_to", timeout_o, 0);
        chk("tie_succ", succ_o, 1);
        chk("tie_cnt", cycle_cnt_o, 1000);

        // All channels disabled: done on the first edge.
        rst   = 1'b1;
        ch_en = '0;
        tick();
        rst = 1'b0;
        tick();
        chk("dis_over", over_o, 1);
        chk("dis_succ", succ_o, 1);
        chk("dis_mask", done_mask_o, 0);

        // Reset mid-run discards latched results.
        ch_en = '1;
        do_reset();
        set_regs(1, 1, 0, 0);
        repeat (3) tick();
        set_regs(0, 1, 0, 0);
        repeat (3) tick();
        chk("mid_mask", done_mask_o, 2'b01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_mask", done_mask_o, 0);
        chk("mid_rst_cnt", cycle_cnt_o, 0);

        // Random runs against the model.
        for (int r = 0; r < 12; r++) begin
            ch_en = NCH'($urandom_range(0, 3));
            do_reset();
            for (int c = 0; c < 60; c++) begin
                logic [DW-1:0] d0, d1, p0, p1;
                d0 = ($urandom_range(0, 2) == 0) ? DW'($urandom_range(1, 9)) : '0;
                d1 = ($urandom_range(0, 2) == 0) ? DW'($urandom_range(1, 9)) : '0;
                p0 = ($urandom_range(0, 3) == 0) ? DW'($urandom) : '0;
                p1 = ($urandom_range(0, 3) == 0) ? DW'($urandom) : '0;
                set_regs(d0, d1, p0, p1);
                clr_i = ($urandom_range(0, 39) == 0);
                tick();
                clr_i = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
